// File: rtl/mole_dispatcher.sv
// mole_dispatcher: picks a pseudo-random hole and mole type, shows it for a
// level-dependent dwell, retires it on hit_ack or on timeout with a miss pulse.
module mole_dispatcher #(
    parameter int unsigned DWELL_L1   = 125000000,
    parameter int unsigned DWELL_L2   = 80000000,
    parameter int unsigned GAP_CYCLES = 12500000,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] level,
    input  logic       hit_ack,
    output logic [3:0] anode_en,
    output logic [2:0] mole_type,
    output logic [6:0] seg,
    output logic       mole_valid,
    output logic       mole_new,
    output logic       miss
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GAP  = 2'd1,
        SHOW = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [1:0]  prev_q, prev_d;

    logic [3:0]  anode_d;
    logic [2:0]  type_d;
    logic [6:0]  seg_d;
    logic        valid_d, new_d, miss_d;
    logic        blank;

    logic        level_ok;
    logic        lfsr_fb;
    logic [1:0]  cand;
    logic [1:0]  hole;

    function automatic logic [6:0] glyph(input logic [2:0] t);
        case (t)
            3'd0:    glyph = 7'b1100000;
            3'd1:    glyph = 7'b1001111;
            3'd2:    glyph = 7'b0010010;
            3'd3:    glyph = 7'b0000110;
            default: glyph = 7'b1111111;
        endcase
    endfunction

    assign level_ok = (level == 4'd1) || (level == 4'd2);
    assign lfsr_fb  = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    assign cand     = lfsr_q[1:0];
    // Bump to the neighbouring hole so a mole never reappears in place
    assign hole     = (cand == prev_q) ? cand + 2'd1 : cand;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lfsr_d  = lfsr_q;
        prev_d  = prev_q;
        anode_d = anode_en;
        type_d  = mole_type;
        seg_d   = seg;
        valid_d = mole_valid;
        new_d   = 1'b0;
        miss_d  = 1'b0;
        blank   = 1'b0;

        if (enable) begin
            lfsr_d = {lfsr_fb, lfsr_q[15:1]};
            if (!level_ok) begin
                state_d = IDLE;
                blank   = 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_d = GAP;
                        cnt_d   = GAP_CYCLES - 1;
                    end
                    GAP: begin
                        if (cnt_q == 32'd0) begin
                            state_d = SHOW;
                            cnt_d   = (level == 4'd1) ? DWELL_L1 - 1
                                                      : DWELL_L2 - 1;
                            prev_d  = hole;
                            anode_d = ~(4'b0001 << hole);
                            type_d  = {1'b0, lfsr_q[3:2]};
                            seg_d   = glyph({1'b0, lfsr_q[3:2]});
                            valid_d = 1'b1;
                            new_d   = 1'b1;
                        end else begin
                            cnt_d = cnt_q - 32'd1;
                        end
                    end
                    SHOW: begin
                        if (hit_ack) begin
                            state_d = GAP;
                            cnt_d   = GAP_CYCLES - 1;
                            blank   = 1'b1;
                        end else if (cnt_q == 32'd0) begin
                            state_d = GAP;
                            cnt_d   = GAP_CYCLES - 1;
                            blank   = 1'b1;
                            miss_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_q - 32'd1;
                        end
                    end
                    default: begin
                        state_d = GAP;
                        cnt_d   = GAP_CYCLES - 1;
                        blank   = 1'b1;
                    end
                endcase
            end
            if (blank) begin
                anode_d = 4'b1111;
                type_d  = 3'd7;
                seg_d   = 7'b1111111;
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= GAP;
            cnt_q      <= GAP_CYCLES - 1;
            lfsr_q     <= LFSR_SEED;
            prev_q     <= 2'd0;
            anode_en   <= 4'b1111;
            mole_type  <= 3'd7;
            seg        <= 7'b1111111;
            mole_valid <= 1'b0;
            mole_new   <= 1'b0;
            miss       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lfsr_q     <= lfsr_d;
            prev_q     <= prev_d;
            anode_en   <= anode_d;
            mole_type  <= type_d;
            seg        <= seg_d;
            mole_valid <= valid_d;
            mole_new   <= new_d;
            miss       <= miss_d;
        end
    end

endmodule

// File: doc/mole_dispatcher.md
# mole_dispatcher

Producer end of the mole interface consumed by the game scorer. Picks a pseudo-random hole and mole type, shows the mole for a level-dependent dwell time, and retires it early on a hit acknowledge from the scorer or on timeout with a miss pulse. It drives the mole anode enable, mole type and seven-segment mole glyph the scorer and display multiplexer expect, replacing the free-running generator plus frequency counters.

## Interface
- DWELL_L1, default 125000000: visible cycles per mole, level 1
- DWELL_L2, default 80000000: visible cycles per mole, level 2
- GAP_CYCLES, default 12500000: blank cycles between moles
- LFSR_SEED, default 16'hACE1: LFSR reset value, must be non-zero
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- enable  in  1  1 = run; 0 = pause: all counters and state frozen, outputs held
- level  in  4  game level; 1 or 2 valid, anything else = idle
- hit_ack  in  1  one-cycle pulse from scorer: current mole was whacked
- anode_en  out  4  active-low one-hot hole: 1110 hole1, 1101 hole2, 1011 hole3, 0111 hole4; 1111 = none
- mole_type  out  3  0 bomb, 1/2/3 scoring moles; 7 = none
- seg  out  7  active-low {a,b,c,d,e,f,g} glyph of mole_type
- mole_valid  out  1  1 while a mole is shown
- mole_new  out  1  one-cycle pulse on the cycle a new mole first appears
- miss  out  1  one-cycle pulse when a mole times out un-hit

## Operation
- States: IDLE, GAP, SHOW. All outputs registered.
- Reset: state GAP, counter = GAP_CYCLES-1, LFSR = LFSR_SEED, prev_hole = 0, anode_en 1111, mole_type 7, seg 1111111, mole_valid/mole_new/miss 0.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifts every cycle enable=1 (all states), never zero.
- IDLE: entered from any state when level not in {1,2} and enable=1; outputs blank, no miss. Leaves to GAP (counter = GAP_CYCLES-1) when level becomes valid.
- GAP: counter decrements; at 0 -> SHOW. Candidate hole = lfsr[1:0]; if equal to prev_hole, use (lfsr[1:0]+1) mod 4. Type = lfsr[3:2]. Dwell counter loaded with DWELL_L1-1 or DWELL_L2-1 from level sampled on that edge; prev_hole updated.
- SHOW: counter decrements. hit_ack=1 -> GAP next cycle, no miss. Counter 0 and no hit_ack -> GAP with miss=1 on the cycle outputs blank.
- hit_ack outside SHOW or while enable=0 ignored.
- Glyphs: type0 "b" 1100000, type1 "1" 1001111, type2 "2" 0010010, type3 "3" 0000110, none 1111111.
- Level change during SHOW/GAP: current counter unaffected; new dwell applies to next mole. Invalid level overrides: IDLE next enabled cycle, mole dropped without miss.

## Timing
- GAP to SHOW: mole outputs and mole_new=1 appear on the same edge the counter hits 0; GAP lasts exactly GAP_CYCLES enabled cycles.
- Mole visible exactly DWELL_Lx enabled cycles when un-hit; miss asserted for 1 cycle coincident with first blank cycle.
- hit_ack in SHOW cycle k: outputs blank at edge k+1; next mole GAP_CYCLES cycles later.
- hit_ack on final dwell cycle: hit wins, miss stays 0.
- Pause: enable=0 freezes counters mid-count; resumes with remaining count; mole_new/miss never stretched (forced 0 while paused).
- Reset mid-SHOW: blank outputs next edge, no miss, LFSR reseeded.
- Consecutive moles never occupy the same hole.

## Test plan
(DWELL_L1=10, DWELL_L2=6, GAP_CYCLES=4, LFSR_SEED=16'hACE1)
- Reset, level=1, enable=1, no hits -> first mole_new at cycle 4 after reset release, visible 10 cycles, miss pulse on cycle 14, next mole_new at cycle 18; anode_en always one-hot-low during mole_valid, seg matches mole_type.
- hit_ack on 3rd SHOW cycle -> blank next edge, miss=0, next mole_new 4 cycles later.
- hit_ack on 10th (last) SHOW cycle -> miss=0, blank next edge.
- level 1->2 mid-SHOW -> current mole lasts 10 cycles, next lasts 6; level=0 -> IDLE, blank, no miss, restart after GAP on level=1.
- enable=0 for 20 cycles mid-SHOW -> outputs frozen, hit_ack ignored; mole total visible enabled cycles still 10.
- 1000 moles free-run -> no two consecutive equal holes, all four holes and all four types observed, reset mid-SHOW blanks next edge with no miss.
